mole_round_sequencer: RTL
=========================

# mole_round_sequencer

Game-flow controller for the switch/LED target field. It sequences the single-target block by issuing spawn strobes, timing each target's visible window and clearing expired targets. It also keeps score, misses, difficulty level and the game clock. It sits between the 1 ms tick generator / start key and the target block; its count outputs feed the 7-segment display driver.

## Interface
- GAME_SECONDS, 60: game length in seconds (1..99)
- START_WINDOW_MS, 1500: target visible window at level 0
- WINDOW_STEP_MS, 100: window reduction per level
- MIN_WINDOW_MS, 300: window floor
- GAP_MS, 200: blank time between targets
- HITS_PER_LEVEL, 5: hits needed to advance one level
- MAX_MISSES, 5: misses that end the game (1..7)

- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse from the debounced start key
- tick_ms  in  1  one-cycle strobe, once per millisecond
- hit  in  1  one-cycle pulse from the target block when the current target is hit
- target_active  in  1  high while the target block holds a nonzero target
- spawn_tick  out  1  one-cycle request to the target block to load a new target
- clear_target  out  1  one-cycle request to the target block to blank an expired target
- score  out  14  hits this game, saturating at 9999
- misses  out  3  expired targets this game
- level  out  4  difficulty level, saturating at 15
- time_left  out  7  seconds remaining
- window_ms  out  11  current visible window in ms
- game_over  out  1  high in the OVER state
- state  out  3  FSM state encoding, for debug display

## Operation
- States, in order of encoding 0..5: IDLE, GAP, SPAWN, WAIT_UP, ACTIVE, OVER.
- IDLE
  - On `start`: clear score, misses, level, hit-in-level count and ms counter; load time_left=GAME_SECONDS; go to GAP.
- GAP
  - Count tick_ms up to GAP_MS, then go to SPAWN.
- SPAWN
  - Assert spawn_tick for exactly one cycle, then go to WAIT_UP.
- WAIT_UP
  - If target_active is seen within 4 cycles: clear the ms counter and go to ACTIVE.
  - Otherwise go back to SPAWN. This covers an out-of-range random position, which produces no target.
- ACTIVE
  - On `hit`:
    - score+1 (saturate at 9999) and hit-in-level count+1.
    - When the hit-in-level count reaches HITS_PER_LEVEL: reset it to 0 and set level+1 (saturate at 15).
    - Go to GAP.
  - On window expiry (ms count reaches window_ms):
    - Pulse clear_target and set misses+1.
    - If misses is now MAX_MISSES, go to OVER; otherwise go to GAP.
- OVER
  - game_over=1 and all counters are held.
  - On `start`: same action as from IDLE.
- Window arithmetic
  - window_ms = max(MIN_WINDOW_MS, START_WINDOW_MS − level×WINDOW_STEP_MS).
  - Computed with signed or guarded arithmetic, so it never underflows.
- Game clock
  - Runs in GAP, SPAWN, WAIT_UP and ACTIVE.
  - A 10-bit ms prescaler decrements time_left every 1000 tick_ms.
  - When time_left reaches 0: pulse clear_target if a target is up, then go to OVER.
- Ignored inputs
  - `hit` outside ACTIVE.
  - `start` outside IDLE and OVER.
  - tick_ms in IDLE and OVER.

## Timing
- Reset values
  - State returns to IDLE.
  - spawn_tick=0, clear_target=0, score=0, misses=0, level=0, game_over=0.
  - time_left=GAME_SECONDS and window_ms=START_WINDOW_MS.
- Outputs
  - All outputs are registered.
  - spawn_tick is high in the cycle after SPAWN is entered.
  - target_active is expected one cycle after spawn_tick.
- Latency
  - hit is registered into score one cycle after the hit pulse.
  - A new spawn follows exactly GAP_MS ticks after the hit.
- Simultaneous events
  - hit and expiry in the same cycle: the hit wins; no miss is counted and clear_target is not pulsed.
  - hit and time_left reaching 0 in the same cycle: the score is counted, then OVER.
  - Miss limit and time expiry in the same cycle: go to OVER once, with a single clear_target pulse.
- Reset mid-game aborts immediately to IDLE with no spawn_tick or clear_target pulse.

## Test plan
- Reset, then start, then no hits with defaults:
  - spawn_tick after 200 ticks.
  - clear_target 1500 ticks after target_active.
  - After 5 misses: game_over=1, state=5.
- Hit 1 cycle after each target_active, repeated 5 times:
  - score=5, level=1, window_ms=1400.
- Drive level to 15 through 75 hits:
  - window_ms=300 (floor).
  - level stays at 15 on the next 5 hits.
- Hold target_active low after spawn_tick:
  - spawn_tick repeats every 6 cycles.
  - misses stays 0.
- Simultaneous hit and expiry:
  - score+1, misses unchanged, no clear_target pulse.
- 60000 tick_ms with a target up at the end:
  - time_left steps 60→0.
  - clear_target pulses once, then OVER.
  - start restarts with score=0 and time_left=60.

Source files
------------

// File: rtl/mole_round_sequencer.sv
// mole_round_sequencer: game-flow controller for the switch/LED target field.
// Spawns and clears targets, times windows, keeps score, misses, level and clock.
module mole_round_sequencer #(
  parameter int GAME_SECONDS    = 60,
  parameter int START_WINDOW_MS = 1500,
  parameter int WINDOW_STEP_MS  = 100,
  parameter int MIN_WINDOW_MS   = 300,
  parameter int GAP_MS          = 200,
  parameter int HITS_PER_LEVEL  = 5,
  parameter int MAX_MISSES      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tick_ms,
  input  logic        hit,
  input  logic        target_active,
  output logic        spawn_tick,
  output logic        clear_target,
  output logic [13:0] score,
  output logic [2:0]  misses,
  output logic [3:0]  level,
  output logic [6:0]  time_left,
  output logic [10:0] window_ms,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GAP     = 3'd1;
  localparam logic [2:0] S_SPAWN   = 3'd2;
  localparam logic [2:0] S_WAIT_UP = 3'd3;
  localparam logic [2:0] S_ACTIVE  = 3'd4;
  localparam logic [2:0] S_OVER    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [10:0] ms_q, ms_d;
  logic [9:0]  pre_q, pre_d;
  logic [6:0]  time_q, time_d;
  logic [13:0] score_q, score_d;
  logic [2:0]  miss_q, miss_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  hil_q, hil_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [10:0] win_q, win_d;
  logic        spawn_q, spawn_d;
  logic        clr_q, clr_d;
  logic        over_q, over_d;
  logic        running, sec_tick, time_up;
  logic        hit_a, expire;

  // Signed math keeps the window from wrapping below the floor.
  function automatic logic [10:0] win_of(input logic [3:0] lvl);
    int w;
    w = START_WINDOW_MS - int'(lvl) * WINDOW_STEP_MS;
    if (w < MIN_WINDOW_MS) w = MIN_WINDOW_MS;
    return w[10:0];
  endfunction

  always_comb begin
    running  = state_q inside {S_GAP, S_SPAWN, S_WAIT_UP, S_ACTIVE};
    sec_tick = running && tick_ms && (pre_q == 10'd999);
    time_up  = sec_tick && (time_q == 7'd1);
    hit_a    = (state_q == S_ACTIVE) && hit;
    expire   = (state_q == S_ACTIVE) && !hit && tick_ms
               && ((ms_q + 11'd1) == win_q);

    state_d = state_q;
    ms_d    = ms_q;
    pre_d   = pre_q;
    time_d  = time_q;
    score_d = score_q;
    miss_d  = miss_q;
    level_d = level_q;
    hil_d   = hil_q;
    wcnt_d  = wcnt_q;
    spawn_d = 1'b0;
    clr_d   = 1'b0;

    if (running && tick_ms) begin
      pre_d = (pre_q == 10'd999) ? 10'd0 : pre_q + 10'd1;
    end
    if (sec_tick) time_d = time_q - 7'd1;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_d = '0;
          miss_d  = '0;
          level_d = '0;
          hil_d   = '0;
          ms_d    = '0;
          pre_d   = '0;
          wcnt_d  = '0;
          time_d  = 7'(GAME_SECONDS);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick_ms) begin
          if ((ms_q + 11'd1) == 11'(GAP_MS)) begin
            ms_d    = '0;
            state_d = S_SPAWN;
          end else begin
            ms_d = ms_q + 11'd1;
          end
        end
      end
      S_SPAWN: begin
        spawn_d = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT_UP;
      end
      S_WAIT_UP: begin
        if (target_active) begin
          ms_d    = '0;
          state_d = S_ACTIVE;
        end else if (wcnt_q == 3'd4) begin
          state_d = S_SPAWN;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_ACTIVE: begin
        if (hit) begin
          if (score_q != 14'd9999) score_d = score_q + 14'd1;
          if ((hil_q + 8'd1) == 8'(HITS_PER_LEVEL)) begin
            hil_d = '0;
            if (level_q != 4'd15) level_d = level_q + 4'd1;
          end else begin
            hil_d = hil_q + 8'd1;
          end
          ms_d    = '0;
          state_d = S_GAP;
        end else if (expire) begin
          clr_d   = 1'b1;
          miss_d  = miss_q + 3'd1;
          ms_d    = '0;
          state_d = ((miss_q + 3'd1) == 3'(MAX_MISSES)) ? S_OVER : S_GAP;
        end else if (tick_ms) begin
          ms_d = ms_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clock expiry overrides every running transition.
    if (time_up) begin
      state_d = S_OVER;
      if (target_active && !hit_a) clr_d = 1'b1;
    end

    win_d  = win_of(level_d);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
      pre_q   <= '0;
      time_q  <= 7'(GAME_SECONDS);
      score_q <= '0;
      miss_q  <= '0;
      level_q <= '0;
      hil_q   <= '0;
      wcnt_q  <= '0;
      win_q   <= 11'(START_WINDOW_MS);
      spawn_q <= 1'b0;
      clr_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      pre_q   <= pre_d;
      time_q  <= time_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      level_q <= level_d;
      hil_q   <= hil_d;
      wcnt_q  <= wcnt_d;
      win_q   <= win_d;
      spawn_q <= spawn_d;
      clr_q   <= clr_d;
      over_q  <= over_d;
    end
  end

  assign spawn_tick   = spawn_q;
  assign clear_target = clr_q;
  assign score        = score_q;
  assign misses       = miss_q;
  assign level        = level_q;
  assign time_left    = time_q;
  assign window_ms    = win_q;
  assign game_over    = over_q;
  assign state        = state_q;

endmodule
